// File: rtl/ascii_operand_parser_pkg.sv
// ascii_operand_parser_pkg: ASCII codes and parser state encoding shared by the operand parser
package ascii_operand_parser_pkg;
    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_9 = 8'h39;
    localparam logic [7:0] LF_CODE = 8'h0A;
    localparam logic [7:0] CR_CODE = 8'h0D;
    typedef enum logic [2:0] {
        X_D0 = 3'd0, X_D1 = 3'd1, X_D2 = 3'd2,
        Y_D0 = 3'd3, Y_D1 = 3'd4, Y_D2 = 3'd5,
        HOLD = 3'd6
    } state_e;
endpackage

// File: rtl/ascii_operand_parser_digit_decode.sv
// ascii_digit_decode: classifies an ASCII byte as decimal digit or Enter and extracts the digit value
module ascii_digit_decode
    import ascii_operand_parser_pkg::*;
#(
    parameter logic [7:0] ENTER_LF = LF_CODE,
    parameter logic [7:0] ENTER_CR = CR_CODE
) (
    input  logic [7:0] char_data,
    output logic       is_digit,
    output logic       is_enter,
    output logic [3:0] digit
);
    always_comb begin
        is_digit = (char_data >= ASCII_0) && (char_data <= ASCII_9);
        is_enter = (char_data == ENTER_LF) || (char_data == ENTER_CR);
        digit    = char_data[3:0];
    end
endmodule

// File: rtl/ascii_operand_parser.sv
// ascii_operand_parser: turns two Enter-terminated ASCII decimal entries into an X/Y operand pair with handshake
module ascii_operand_parser
    import ascii_operand_parser_pkg::*;
#(
    parameter int         OP_W     = 5,
    parameter logic [7:0] ENTER_LF = LF_CODE,
    parameter logic [7:0] ENTER_CR = CR_CODE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            char_valid,
    input  logic [7:0]      char_data,
    output logic            char_ready,
    output logic [OP_W-1:0] op_x,
    output logic [OP_W-1:0] op_y,
    output logic            op_valid,
    input  logic            op_ready,
    output logic            range_err,
    output logic            char_err
);
    state_e          state_q, state_d;
    logic [6:0]      acc_q, acc_d, acc10;
    logic [OP_W-1:0] op_x_q, op_x_d, op_y_q, op_y_d;
    logic            rng_x_q, rng_x_d, op_valid_q, op_valid_d;
    logic            range_err_q, range_err_d, char_err_q, char_err_d;
    logic            is_digit, is_enter, first, last, is_y, big;
    logic [3:0]      digit;

    ascii_digit_decode #(.ENTER_LF(ENTER_LF), .ENTER_CR(ENTER_CR)) u_dec (
        .char_data(char_data),
        .is_digit (is_digit),
        .is_enter (is_enter),
        .digit    (digit)
    );

    always_comb begin
        first       = (state_q == X_D0) || (state_q == Y_D0);
        last        = (state_q == X_D2) || (state_q == Y_D2);
        is_y        = (state_q == Y_D0) || (state_q == Y_D1) || (state_q == Y_D2);
        acc10       = {acc_q[3:0], 3'b000} + {acc_q[5:0], 1'b0};
        big         = acc_q > 7'((1 << OP_W) - 1);
        state_d     = state_q;
        acc_d       = acc_q;
        op_x_d      = op_x_q;
        op_y_d      = op_y_q;
        rng_x_d     = rng_x_q;
        op_valid_d  = op_valid_q;
        range_err_d = range_err_q;
        char_err_d  = 1'b0;
        if (state_q == HOLD) begin
            if (op_ready) begin
                op_valid_d = 1'b0;
                state_d    = X_D0;
            end
        end else if (char_valid) begin
            if (is_digit && !last) begin
                acc_d   = first ? {3'd0, digit} : acc10 + {3'd0, digit};
                state_d = state_e'(state_q + 3'd1);
            end else if (is_enter) begin
                if (!first) begin
                    acc_d = '0;
                    if (is_y) begin
                        op_y_d      = acc_q[OP_W-1:0];
                        op_valid_d  = 1'b1;
                        range_err_d = rng_x_q | big;
                        state_d     = HOLD;
                    end else begin
                        op_x_d  = acc_q[OP_W-1:0];
                        rng_x_d = big;
                        state_d = Y_D0;
                    end
                end
            end else begin
                // any abort restarts the whole pair, discarding a committed X
                char_err_d = 1'b1;
                acc_d      = '0;
                state_d    = X_D0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= X_D0;
            acc_q       <= '0;
            op_x_q      <= '0;
            op_y_q      <= '0;
            rng_x_q     <= 1'b0;
            op_valid_q  <= 1'b0;
            range_err_q <= 1'b0;
            char_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            op_x_q      <= op_x_d;
            op_y_q      <= op_y_d;
            rng_x_q     <= rng_x_d;
            op_valid_q  <= op_valid_d;
            range_err_q <= range_err_d;
            char_err_q  <= char_err_d;
        end
    end

    assign char_ready = state_q != HOLD;
    assign op_x       = op_x_q;
    assign op_y       = op_y_q;
    assign op_valid   = op_valid_q;
    assign range_err  = range_err_q;
    assign char_err   = char_err_q;
endmodule

// File: tb/tb_ascii_operand_parser.sv
// tb_ascii_operand_parser: directed scoreboard bench for the ASCII operand parser
module tb_ascii_operand_parser;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       char_valid = 1'b0;
    logic [7:0] char_data = 8'h00;
    logic       char_ready;
    logic [4:0] op_x, op_y;
    logic       op_valid;
    logic       op_ready = 1'b0;
    logic       range_err, char_err;

    typedef struct packed {
        logic [4:0] x;
        logic [4:0] y;
        logic       r;
    } exp_t;
    exp_t sb[$];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ascii_operand_parser dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .char_valid(char_valid),
        .char_data (char_data),
        .char_ready(char_ready),
        .op_x      (op_x),
        .op_y      (op_y),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .range_err (range_err),
        .char_err  (char_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] c);
        int n = 0;
        char_valid = 1'b1;
        char_data  = c;
        while (!char_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!char_ready) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        char_valid = 1'b0;
    endtask

    task automatic take(input string tag);
        exp_t e;
        int n = 0;
        while (!op_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_valid"}, op_valid, 1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_x"}, op_x, e.x);
            chk({tag, "_y"}, op_y, e.y);
            chk({tag, "_rng"}, range_err, e.r);
        end
        op_ready = 1'b1;
        @(posedge clk); #1;
        op_ready = 1'b0;
        chk({tag, "_drop"}, op_valid, 0);
        chk({tag, "_ready"}, char_ready, 1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_x"}, op_x, 0);
        chk({tag, "_y"}, op_y, 0);
        chk({tag, "_valid"}, op_valid, 0);
        chk({tag, "_rng"}, range_err, 0);
        chk({tag, "_cerr"}, char_err, 0);
        chk({tag, "_cready"}, char_ready, 1);
    endtask

    initial begin
        #2;
        check_reset("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        sb.push_back('{x: 5'd25, y: 5'd7, r: 1'b0});
        send("2"); send("5"); send(8'h0A); send("0"); send("7"); send(8'h0A);
        chk("latency", op_valid, 1);
        take("p25_7");

        sb.push_back('{x: 5'd8, y: 5'd1, r: 1'b1});
        send("4"); send("0"); send(8'h0D); send("1"); send(8'h0A);
        take("p40_1");

        send("3"); send("a");
        chk("err_pulse", char_err, 1);
        chk("err_novalid", op_valid, 0);
        chk("err_x_kept", op_x, 8);
        @(posedge clk); #1;
        chk("err_one_cycle", char_err, 0);
        sb.push_back('{x: 5'd12, y: 5'd3, r: 1'b0});
        send("1"); send("2"); send(8'h0A); send("3"); send(8'h0A);
        take("p12_3");

        sb.push_back('{x: 5'd5, y: 5'd6, r: 1'b0});
        send("5"); send(8'h0A); send("6"); send(8'h0A);
        char_valid = 1'b1;
        char_data  = "7";
        for (int i = 0; i < 4; i++) begin
            chk("hold_cready", char_ready, 0);
            chk("hold_x", op_x, 5);
            chk("hold_y", op_y, 6);
            chk("hold_valid", op_valid, 1);
            @(posedge clk); #1;
        end
        take("p5_6");
        @(posedge clk); #1;
        char_valid = 1'b0;
        sb.push_back('{x: 5'd7, y: 5'd8, r: 1'b0});
        send(8'h0A); send("8"); send(8'h0A);
        take("p7_8");

        send("9"); send("9"); send(8'h0A); send("1");
        #2 rst_n = 1'b0;
        #1;
        check_reset("midrst");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        sb.push_back('{x: 5'd0, y: 5'd31, r: 1'b0});
        send("0"); send("0"); send(8'h0A); send("3"); send("1"); send(8'h0A);
        take("p0_31");

        send(8'h0A); send(8'h0A);
        chk("lf_ignored", char_err, 0);
        send("1"); send("2"); send("3");
        chk("third_digit_err", char_err, 1);
        sb.push_back('{x: 5'd4, y: 5'd5, r: 1'b0});
        send("4"); send(8'h0A); send("5"); send(8'h0A);
        take("p4_5");

        sb.push_back('{x: 5'd3, y: 5'd2, r: 1'b1});
        send("9"); send("9"); send(8'h0D); send("2"); send(8'h0A);
        take("p99_2");

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
